// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD display feed.
// Also holds the leading-zero blanking helper used when BCD_BLANK_LEADING_EN is defined.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        FINISH
    } state_t;

    localparam int          BCD_DIGITS = 8;
    localparam logic [3:0]  BCD_BLANK  = 4'hF;
    localparam logic [26:0] BCD_MAX    = 27'd99_999_999;
    localparam logic [31:0] BCD_SAT    = 32'h9999_9999;

    // Replace zero digits from the top down until the first nonzero digit; digit 0 always shows.
    function automatic logic [31:0] blank_leading(input logic [31:0] digits);
        logic [31:0] res;
        logic        lead;
        res  = digits;
        lead = 1'b1;
        for (int i = BCD_DIGITS - 1; i > 0; i--) begin
            if (lead && (digits[4*i +: 4] == 4'h0)) begin
                res[4*i +: 4] = BCD_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_display_feed_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_add3_digit (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;
    end

endmodule

// File: rtl/bcd_display_feed.sv
// Iterative shift-and-add-3 binary-to-BCD converter feeding the eight-digit display driver.
// Define BCD_BLANK_LEADING_EN to blank leading zero digits (rendered as 4'hF).
module bcd_display_feed
    import bcd_pkg::*;
#(
    parameter int WIDTH = 27
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [31:0]      bcd
);

    localparam int SR_W  = 32 + WIDTH;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef BCD_BLANK_LEADING_EN
    localparam logic [31:0] BCD_RST = 32'hFFFF_FFF0;
`else
    localparam logic [31:0] BCD_RST = 32'h0000_0000;
`endif

    state_t            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_pend_q, ovf_pend_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       bcd_q, bcd_d;

    logic [31:0]       adj;
    logic [SR_W-1:0]   corr;
    logic [31:0]       result;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_dig
        bcd_add3_digit u_add3 (
            .digit_i (sr_q[WIDTH + 4*g +: 4]),
            .digit_o (adj[4*g +: 4])
        );
    end

    assign corr = {adj, sr_q[WIDTH-1:0]};

`ifdef BCD_BLANK_LEADING_EN
    assign result = blank_leading(sr_q[SR_W-1 -: 32]);
`else
    assign result = sr_q[SR_W-1 -: 32];
`endif

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d       = {32'b0, value};
                    cnt_d      = '0;
                    ovf_pend_d = (32'(value) > 32'(BCD_MAX));
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                sr_d  = corr << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                // Saturation takes priority over blanking.
                bcd_d   = ovf_pend_q ? BCD_SAT : result;
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            bcd_q   <= BCD_RST;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            bcd_q   <= bcd_d;
        end
    end

    // Datapath registers are always loaded before use, so they carry no reset.
    always_ff @(posedge clock) begin
        sr_q       <= sr_d;
        cnt_q      <= cnt_d;
        ovf_pend_q <= ovf_pend_d;
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign bcd      = bcd_q;

endmodule

// File: tb/tb_bcd_display_feed.sv
// Scoreboard bench for bcd_display_feed: driver queues expected results, monitor checks on done.
module tb_bcd_display_feed;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [26:0] value;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [31:0] bcd;

`ifdef BCD_BLANK_LEADING_EN
    localparam bit          BLANK   = 1'b1;
    localparam logic [31:0] RST_BCD = 32'hFFFF_FFF0;
`else
    localparam bit          BLANK   = 1'b0;
    localparam logic [31:0] RST_BCD = 32'h0000_0000;
`endif

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    bcd_display_feed #(.WIDTH(27)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .bcd      (bcd)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clock) begin
        if (done) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got bcd %h with no conversion pending (cycle %0d)", bcd, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("bcd", 64'(bcd), 64'(e.bcd));
                chk("overflow", 64'(overflow), 64'(e.ovf));
                chk("latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    function automatic logic [31:0] pick(input logic [31:0] plain, input logic [31:0] blanked);
        return BLANK ? blanked : plain;
    endfunction

    task automatic issue(input logic [26:0] v, input logic [31:0] e, input logic o);
        @(negedge clock);
        start = 1'b1;
        value = v;
        @(posedge clock);
        #1;
        q.push_back('{bcd: e, ovf: o, due: cyc + 28});
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clock);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        value = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_bcd", 64'(bcd), 64'(RST_BCD));
        reset = 1'b0;

        issue(27'd0,          pick(32'h0000_0000, 32'hFFFF_FFF0), 1'b0); drain();
        issue(27'd12_345_678, 32'h1234_5678,                      1'b0); drain();
        issue(27'd99_999_999, 32'h9999_9999,                      1'b0); drain();
        issue(27'd100_000_000, 32'h9999_9999,                     1'b1); drain();
        issue(27'd7,          pick(32'h0000_0007, 32'hFFFF_FFF7), 1'b0); drain();
        issue(27'h7FF_FFFF,   32'h9999_9999,                      1'b1); drain();
        issue(27'd10_000_000, 32'h1000_0000,                      1'b0); drain();

        // busy must be high mid-conversion, and a second start is ignored
        issue(27'd305, pick(32'h0000_0305, 32'hFFFF_F305), 1'b0);
        repeat (3) @(negedge clock);
        chk("busy_mid", 64'(busy), 64'd1);
        start = 1'b1;
        value = 27'd999;
        @(negedge clock);
        start = 1'b0;
        drain();
        repeat (40) @(negedge clock);

        // reset at cycle 10 of a conversion: nothing queued, so any done is spurious
        @(negedge clock);
        start = 1'b1;
        value = 27'd4321;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_bcd", 64'(bcd), 64'(RST_BCD));
        chk("midrst_done", 64'(done), 64'd0);
        // start during reset is dropped
        start = 1'b1;
        value = 27'd55;
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        chk("rststart_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clock);

        // start held high: back-to-back conversions every 29 cycles
        @(negedge clock);
        start = 1'b1;
        value = 27'd42;
        @(posedge clock);
        #1;
        q.push_back('{bcd: pick(32'h0000_0042, 32'hFFFF_FF42), ovf: 1'b0, due: cyc + 28});
        @(negedge clock);
        value = 27'd1000;
        repeat (29) @(posedge clock);
        #1;
        q.push_back('{bcd: pick(32'h0000_1000, 32'hFFFF_1000), ovf: 1'b0, due: cyc + 28});
        @(negedge clock);
        value = 27'd5;
        repeat (29) @(posedge clock);
        #1;
        q.push_back('{bcd: pick(32'h0000_0005, 32'hFFFF_FFF5), ovf: 1'b0, due: cyc + 28});
        @(negedge clock);
        start = 1'b0;
        drain();
        repeat (35) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
